// File: rtl/clk_div_2n.sv
// clk_div_2n: flop-driven 50%-duty clock at clk_in/(2*DIV_2N); power-up state is 0 so reset may be tied low.
// Optional macro CLOCK_DIV_STROBE_EN adds registered rise_stb/fall_stb edge strobes.
module clk_div_2n #(
  parameter int DIV_2N = 1
) (
  input  logic clk_in,
  input  logic reset,
`ifdef CLOCK_DIV_STROBE_EN
  output logic rise_stb,
  output logic fall_stb,
`endif
  output logic clk_out
);
  localparam int CNT_W = (DIV_2N > 1) ? $clog2(DIV_2N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_2N - 1);
  generate
    if (DIV_2N < 1) begin : g_bad_div
      $error("clk_div_2n: DIV_2N must be >= 1");
    end
  endgenerate
  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;
  logic             clk_q = 1'b0;
  logic             clk_d;
  logic             wrap;
  always_comb begin
    wrap  = cnt_q == CNT_MAX;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    clk_d = clk_q ^ wrap;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end
  assign clk_out = clk_q;
`ifdef CLOCK_DIV_STROBE_EN
  // Strobes load on the same edge as clk_q, so each is high exactly in the first cycle of the new level.
  logic rise_q = 1'b0;
  logic fall_q = 1'b0;
  always_ff @(posedge clk_in) begin
    rise_q <= ~reset & wrap & ~clk_q;
    fall_q <= ~reset & wrap & clk_q;
  end
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
`endif
endmodule

// File: tb/tb_clk_div_2n.sv
// tb_clk_div_2n: directed checks of clk_div_2n for DIV_2N = 1, 2, 3, 4, 5 against closed-form expectations.
module tb_clk_div_2n;
  logic clk = 1'b0;
  logic r1 = 1'b1, r3 = 1'b1, r4 = 1'b1, r5 = 1'b1;
  logic tie0 = 1'b0;
  logic o1, o2, o3, o4, o5;
  int edges = 0;
  int checks = 0;
  int errors = 0;
`ifdef CLOCK_DIV_STROBE_EN
  logic rs1, fs1, rs2, fs2, rs3, fs3, rs4, fs4, rs5, fs5;
  clk_div_2n #(.DIV_2N(1)) u1 (.clk_in(clk), .reset(r1), .rise_stb(rs1), .fall_stb(fs1), .clk_out(o1));
  clk_div_2n #(.DIV_2N(2)) u2 (.clk_in(clk), .reset(tie0), .rise_stb(rs2), .fall_stb(fs2), .clk_out(o2));
  clk_div_2n #(.DIV_2N(3)) u3 (.clk_in(clk), .reset(r3), .rise_stb(rs3), .fall_stb(fs3), .clk_out(o3));
  clk_div_2n #(.DIV_2N(4)) u4 (.clk_in(clk), .reset(r4), .rise_stb(rs4), .fall_stb(fs4), .clk_out(o4));
  clk_div_2n #(.DIV_2N(5)) u5 (.clk_in(clk), .reset(r5), .rise_stb(rs5), .fall_stb(fs5), .clk_out(o5));
`else
  clk_div_2n #(.DIV_2N(1)) u1 (.clk_in(clk), .reset(r1), .clk_out(o1));
  clk_div_2n #(.DIV_2N(2)) u2 (.clk_in(clk), .reset(tie0), .clk_out(o2));
  clk_div_2n #(.DIV_2N(3)) u3 (.clk_in(clk), .reset(r3), .clk_out(o3));
  clk_div_2n #(.DIV_2N(4)) u4 (.clk_in(clk), .reset(r4), .clk_out(o4));
  clk_div_2n #(.DIV_2N(5)) u5 (.clk_in(clk), .reset(r5), .clk_out(o5));
`endif
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edges);
    end
  endtask
  function automatic logic lvl(input int k, input int d);
    return ((k / d) % 2) == 1;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_free();
    check("d2_free_clk", 32'(o2), 32'(lvl(edges, 2)));
    check("d2_no_x", 32'($isunknown(o2)), 32'd0);
`ifdef CLOCK_DIV_STROBE_EN
    check("d2_rise", 32'(rs2), 32'(edges % 4 == 2));
    check("d2_fall", 32'(fs2), 32'(edges % 4 == 0));
`endif
  endtask
  initial begin
    #1;
    check("d2_power_up", 32'(o2), 32'd0);
    check("d2_power_up_x", 32'($isunknown(o2)), 32'd0);
    step();
    check_free();
    step();
    check_free();
    check("d1_reset", 32'(o1), 32'd0);
    check("d3_reset", 32'(o3), 32'd0);
    check("d4_reset", 32'(o4), 32'd0);
    check("d4_reset_cnt", 32'(u4.cnt_q), 32'd0);
`ifdef CLOCK_DIV_STROBE_EN
    check("d4_reset_rise", 32'(rs4), 32'd0);
`endif
    r1 = 1'b0;
    r3 = 1'b0;
    r4 = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step();
      check_free();
      check("d1_clk", 32'(o1), 32'(lvl(k, 1)));
      check("d1_cnt", 32'(u1.cnt_q), 32'd0);
      check("d3_clk", 32'(o3), 32'(lvl(k, 3)));
      check("d3_cnt", 32'(u3.cnt_q), 32'(k % 3));
      check("d4_clk", 32'(o4), 32'(lvl(k, 4)));
      check("d4_cnt", 32'(u4.cnt_q), 32'(k % 4));
      check("d5_held", 32'(o5), 32'd0);
`ifdef CLOCK_DIV_STROBE_EN
      check("d1_rise", 32'(rs1), 32'(k % 2 == 1));
      check("d1_fall", 32'(fs1), 32'(k % 2 == 0));
      check("d4_rise", 32'(rs4), 32'(k % 8 == 4));
      check("d4_fall", 32'(fs4), 32'(k % 8 == 0));
      check("d5_held_rise", 32'(rs5), 32'd0);
`endif
    end
    r5 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("d5_clk", 32'(o5), 32'(lvl(k, 5)));
      check("d5_cnt", 32'(u5.cnt_q), 32'(k % 5));
    end
    r5 = 1'b1;
    step();
    check("d5_midreset_clk", 32'(o5), 32'd0);
    check("d5_midreset_cnt", 32'(u5.cnt_q), 32'd0);
`ifdef CLOCK_DIV_STROBE_EN
    check("d5_midreset_fall", 32'(fs5), 32'd0);
`endif
    r5 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("d5_after_clk", 32'(o5), 32'(lvl(k, 5)));
      check("d5_after_cnt", 32'(u5.cnt_q), 32'(k % 5));
`ifdef CLOCK_DIV_STROBE_EN
      check("d5_after_rise", 32'(rs5), 32'(k == 5));
      check("d5_after_fall", 32'(fs5), 32'(k == 10));
`endif
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
